// File: rtl/apb_pkg.sv
// Shared APB bus widths and FSM state type for the core-to-peripheral bridge.
package apb_pkg;

   localparam int APB_AW = 32;
   localparam int APB_DW = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational CPU address -> APB slave decode (hit, slave index, one-hot select).
// Zero latency; no flow control.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int unsigned       NUM_SLV       = 5,
   parameter logic [APB_AW-1:0] BASE_ADDR     = 32'h1000_0000,
   parameter int unsigned       SLV_SPAN_LOG2 = 12,
   localparam int unsigned      IDX_W         = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
   input  logic [APB_AW-1:0]  addr,
   output logic               hit,
   output logic [IDX_W-1:0]   idx,
   output logic [NUM_SLV-1:0] sel
);

   // Window covers 2**IDX_W slave slots; slots at or above NUM_SLV are holes.
   localparam int unsigned WIN_LSB = SLV_SPAN_LOG2 + IDX_W;

   logic in_window;

   assign in_window = (addr[APB_AW-1:WIN_LSB] == BASE_ADDR[APB_AW-1:WIN_LSB]);
   assign idx       = addr[SLV_SPAN_LOG2 +: IDX_W];
   assign hit       = in_window && (32'(idx) < NUM_SLV);

   always_comb begin
      sel = '0;
      for (int i = 0; i < int'(NUM_SLV); i++) begin
         sel[i] = hit && (idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator for the CPU data bus: one request at a time, SETUP/ACCESS with PREADY wait and timeout.
// Completion pulse 2 cycles + ACCESS length after the request; requests arriving while busy are dropped.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned       NUM_SLV       = 5,
   parameter logic [APB_AW-1:0] BASE_ADDR     = 32'h1000_0000,
   parameter int unsigned       SLV_SPAN_LOG2 = 12,
   parameter int unsigned       TIMEOUT       = 255
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                transfer,
   input  logic [APB_AW-1:0]   addr,
   input  logic [APB_DW-1:0]   wdata,
   input  logic                write,
   output logic [APB_DW-1:0]   rdata,
   output logic                ready,
   output logic                err,
   output logic                busy,
   output logic [APB_AW-1:0]   PADDR,
   output logic [APB_DW-1:0]   PWDATA,
   output logic                PWRITE,
   output logic                PENABLE,
   output logic [NUM_SLV-1:0]  PSEL,
   input  logic [APB_DW-1:0]   PRDATA [NUM_SLV],
   input  logic [NUM_SLV-1:0]  PREADY
);

   localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   apb_state_e         state_q;
   logic [NUM_SLV-1:0] sel_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               dec_hit;
   logic [IDX_W-1:0]   dec_idx;
   logic [NUM_SLV-1:0] dec_sel;
   logic               timeout_hit;

   apb_addr_decoder #(
      .NUM_SLV       (NUM_SLV),
      .BASE_ADDR     (BASE_ADDR),
      .SLV_SPAN_LOG2 (SLV_SPAN_LOG2)
   ) u_dec (
      .addr (addr),
      .hit  (dec_hit),
      .idx  (dec_idx),
      .sel  (dec_sel)
   );

   // Fires on the TIMEOUT-th ACCESS cycle; PREADY in that same cycle still wins.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   // Derived from the state register so an async reset drops the bus at once.
   assign busy    = (state_q != IDLE);
   assign PENABLE = (state_q == ACCESS);
   assign PSEL    = busy ? sel_q : '0;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q <= IDLE;
         sel_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         PADDR   <= '0;
         PWDATA  <= '0;
         PWRITE  <= 1'b0;
         ready   <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
         case (state_q)
            IDLE: begin
               if (transfer) begin
                  PADDR  <= addr;
                  PWDATA <= wdata;
                  PWRITE <= write;
                  sel_q  <= dec_sel;
                  idx_q  <= dec_idx;
                  if (dec_hit) begin
                     state_q <= SETUP;
                  end else begin
                     ready <= 1'b1;
                     err   <= 1'b1;
                  end
               end
            end
            SETUP: begin
               cnt_q   <= '0;
               state_q <= ACCESS;
            end
            ACCESS: begin
               if (PREADY[idx_q]) begin
                  state_q <= IDLE;
                  ready   <= 1'b1;
                  if (!PWRITE) begin
                     rdata <= PRDATA[idx_q];
                  end
               end else if (timeout_hit) begin
                  state_q <= IDLE;
                  ready   <= 1'b1;
                  err     <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
